picorv32_mem_copier: RTL
========================

// Module: picorv32_mem_copier
// PURPOSE
//  Bus initiator for the picorv32 native memory interface (valid/ready, addr, wdata, wstrb, rdata).
//  Accepts a copy command (src, dst, word count) and moves words one at a time: read from src, write to dst.
//  Sits beside the core, muxed onto the ROM/RAM memory block; used for boot-time ROM->RAM copy and bulk moves.
//  One word in flight; no internal FIFO beyond a single 32-bit holding register.
// PARAMETERS
//  LEN_W    16   width of cmd_len (word count); max transfer 2^LEN_W-1 words
//  TIMEOUT  256  cycles mem_valid may wait for mem_ready before abort; 0 = never time out
// PORTS
//  clk        in   1      system clock; all logic on rising edge
//  rst        in   1      synchronous reset, active-high
//  cmd_valid  in   1      command present
//  cmd_ready  out  1      engine idle, command accepted on cmd_valid&cmd_ready
//  cmd_src    in   32     source byte address, word aligned
//  cmd_dst    in   32     destination byte address, word aligned
//  cmd_len    in   LEN_W  number of 32-bit words to copy
//  busy       out  1      command in progress
//  done       out  1      one-cycle pulse at end of command (success or error)
//  err        out  1      one-cycle pulse coincident with done on misalignment or timeout
//  mem_valid  out  1      transaction request
//  mem_ready  in   1      responder completes transaction this cycle
//  mem_addr   out  32     byte address
//  mem_wdata  out  32     write data
//  mem_wstrb  out  4      byte strobes; 0 = read, 4'hF = write
//  mem_rdata  in   32     read data, valid when mem_valid&mem_ready
// BEHAVIOUR
//  Reset (rst=1 at edge): state IDLE; cmd_ready=1; busy, done, err, mem_valid=0; mem_addr, mem_wdata=0; mem_wstrb=0.
//  All outputs registered. Reset mid-transfer abandons the command: no done/err pulse, mem_valid low next cycle.
//  States: IDLE, RD, WR, FIN.
//  IDLE: cmd_ready=1. On accept, latch src, dst, len; cmd_ready drops next cycle.
//   - src[1:0]!=0 or dst[1:0]!=0: no memory access; FIN with err.
//   - len==0: FIN without memory access, no err.
//   - else RD.
//  RD: mem_valid=1, mem_addr=src_ptr, mem_wstrb=0. On mem_valid&mem_ready: hold mem_rdata in buffer, src_ptr+=4, go WR.
//  WR: mem_valid=1, mem_addr=dst_ptr, mem_wdata=buffer, mem_wstrb=4'hF. On mem_valid&mem_ready: dst_ptr+=4, remaining-=1;
//   remaining==0 -> FIN, else RD.
//  Handshake: once raised, mem_valid and addr/wdata/wstrb held stable until the cycle mem_ready is sampled high.
//   Next transaction presented the cycle after completion (back-to-back allowed; valid may stay high across).
//   mem_ready while mem_valid=0 is ignored.
//  Per-word cost: 2 handshakes; with a zero-wait responder a copy of N words takes 2N+2 cycles from accept to done.
//  Pointers increment modulo 2^32 (0xFFFF_FFFC + 4 -> 0x0000_0000); no range checks against the memory map.
//  Timeout: counter clears on every handshake; if TIMEOUT!=0 and it reaches TIMEOUT while mem_valid=1,
//   drop mem_valid next cycle and enter FIN with err. A word already read but not written is lost.
//  FIN: done=1 (and err if flagged) for exactly one cycle; busy=0, cmd_ready=1 from the following cycle (IDLE).
//  busy=1 from the cycle after accept through FIN inclusive.
//  cmd_valid while busy: ignored, not queued.
// TESTING
//  T1 src=0x0, dst=0x8000, len=4, zero-wait responder -> 4 reads, 4 writes; RAM[0..3]=ROM[0..3]; done at cycle 10; err=0.
//  T2 len=0 -> no mem_valid; done pulse 2 cycles after accept; err=0.
//  T3 src=0x2 -> err+done, mem_valid never asserted; next cmd accepted normally.
//  T4 random 0-3 cycle waits on mem_ready -> addr/wdata/wstrb stable while waiting; data matches.
//  T5 TIMEOUT=8, mem_ready tied low -> mem_valid drops after 8 cycles; done+err same cycle.
//  T6 rst during WR of word 2 of 5 -> all outputs at reset values next cycle; no done; new cmd completes.

Source files
------------

// File: rtl/picorv32_mem_copier.sv
// Word-copy bus initiator on the picorv32 native memory interface: one word in flight, read then write.
// Latency: 2N+2 cycles accept-to-done with a zero-wait responder; backpressure via mem_ready stalls, cmd_ready low while busy.
module picorv32_mem_copier #(
    parameter int unsigned LEN_W   = 16,
    parameter int unsigned TIMEOUT = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [31:0]      cmd_src,
    input  logic [31:0]      cmd_dst,
    input  logic [LEN_W-1:0] cmd_len,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             mem_valid,
    input  logic             mem_ready,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic [3:0]       mem_wstrb,
    input  logic [31:0]      mem_rdata
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RD   = 2'd1;
    localparam logic [1:0] S_WR   = 2'd2;
    localparam logic [1:0] S_FIN  = 2'd3;

    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    logic [1:0]       state_q, state_d;
    logic [31:0]      src_q, src_d;
    logic [31:0]      dst_q, dst_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic [31:0]      buf_q, buf_d;
    logic             err_flag_q, err_flag_d;
    logic [TW-1:0]    tmo_q, tmo_d;

    logic             cmd_ready_q, busy_q, done_q, err_q, mem_valid_q;
    logic [31:0]      mem_addr_q, mem_addr_d;
    logic [31:0]      mem_wdata_q, mem_wdata_d;
    logic [3:0]       mem_wstrb_q;

    logic             hs;
    logic             tmo_hit;

    assign hs      = mem_valid_q && mem_ready;
    assign tmo_hit = (TIMEOUT != 0) && mem_valid_q && !mem_ready && (tmo_q == TMO_LAST);

    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        dst_d      = dst_q;
        rem_d      = rem_q;
        buf_d      = buf_q;
        err_flag_d = err_flag_q;
        tmo_d      = '0;
        if (mem_valid_q && !mem_ready) begin
            tmo_d = tmo_q + TW'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    src_d      = cmd_src;
                    dst_d      = cmd_dst;
                    rem_d      = cmd_len;
                    err_flag_d = 1'b0;
                    if ((cmd_src[1:0] != 2'b00) || (cmd_dst[1:0] != 2'b00)) begin
                        err_flag_d = 1'b1;
                        state_d    = S_FIN;
                    end else if (cmd_len == '0) begin
                        state_d = S_FIN;
                    end else begin
                        state_d = S_RD;
                    end
                end
            end
            S_RD: begin
                if (hs) begin
                    buf_d   = mem_rdata;
                    src_d   = src_q + 32'd4;
                    state_d = S_WR;
                end else if (tmo_hit) begin
                    err_flag_d = 1'b1;
                    state_d    = S_FIN;
                end
            end
            S_WR: begin
                if (hs) begin
                    dst_d   = dst_q + 32'd4;
                    rem_d   = rem_q - LEN_W'(1);
                    state_d = (rem_q == LEN_W'(1)) ? S_FIN : S_RD;
                end else if (tmo_hit) begin
                    err_flag_d = 1'b1;
                    state_d    = S_FIN;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Bus fields follow the next state so they are valid the same cycle mem_valid rises.
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if (state_d == S_RD) begin
            mem_addr_d = src_d;
        end else if (state_d == S_WR) begin
            mem_addr_d  = dst_d;
            mem_wdata_d = buf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            src_q       <= '0;
            dst_q       <= '0;
            rem_q       <= '0;
            buf_q       <= '0;
            err_flag_q  <= 1'b0;
            tmo_q       <= '0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            mem_valid_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            dst_q       <= dst_d;
            rem_q       <= rem_d;
            buf_q       <= buf_d;
            err_flag_q  <= err_flag_d;
            tmo_q       <= tmo_d;
            cmd_ready_q <= (state_d == S_IDLE);
            busy_q      <= (state_d != S_IDLE);
            done_q      <= (state_d == S_FIN);
            err_q       <= (state_d == S_FIN) && err_flag_d;
            mem_valid_q <= (state_d == S_RD) || (state_d == S_WR);
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= (state_d == S_WR) ? 4'hF : 4'h0;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign mem_valid = mem_valid_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = mem_wstrb_q;

endmodule
